// File: rtl/nova_ram_arb_pkg.sv
// Shared types and default widths for the external frame RAM arbiters.
package nova_ram_arb_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned N_REQ   = 3;
    localparam int unsigned GNT_DF  = 0;
    localparam int unsigned GNT_MC  = 1;
    localparam int unsigned GNT_DIS = 2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DF,
        OWN_MC,
        OWN_DIS
    } owner_e;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    // Owners whose bursts return read data
    function automatic logic is_read_owner(input owner_e owner);
        return (owner == OWN_MC) || (owner == OWN_DIS);
    endfunction

endpackage

// File: rtl/ext_frame_ram_prio_sel.sv
// Fixed-priority DF > MC > DIS select; a starved DIS request jumps to the front.
module ext_frame_ram_prio_sel
    import nova_ram_arb_pkg::*;
(
    input  logic             df_req,
    input  logic             mc_req,
    input  logic             dis_req,
    input  logic             dis_starved,
    output logic [N_REQ-1:0] grant_c
);

    always_comb begin
        grant_c = '0;
        if (dis_req && dis_starved) begin
            grant_c[GNT_DIS] = 1'b1;
        end else if (df_req) begin
            grant_c[GNT_DF] = 1'b1;
        end else if (mc_req) begin
            grant_c[GNT_MC] = 1'b1;
        end else if (dis_req) begin
            grant_c[GNT_DIS] = 1'b1;
        end
    end

endmodule

// File: rtl/ext_frame_ram_arbiter.sv
// Shares one external frame RAM port between DF writeback, MC fetch and display
// readout: arbitrates in IDLE, runs the burst, and steers read data to its owner.
module ext_frame_ram_arbiter
    import nova_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = nova_ram_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W       = nova_ram_arb_pkg::DATA_W,
    parameter int unsigned LEN_W        = nova_ram_arb_pkg::LEN_W,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              df_req,
    input  logic [ADDR_W-1:0] df_addr,
    input  logic [LEN_W-1:0]  df_len,
    input  logic [DATA_W-1:0] df_wdata,
    output logic              df_gnt,
    output logic              df_wready,

    input  logic              mc_req,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [LEN_W-1:0]  mc_len,
    output logic              mc_gnt,
    output logic              mc_rvalid,
    output logic [DATA_W-1:0] mc_rdata,

    input  logic              dis_req,
    input  logic [ADDR_W-1:0] dis_addr,
    input  logic [LEN_W-1:0]  dis_len,
    output logic              dis_gnt,
    output logic              dis_rvalid,
    output logic [DATA_W-1:0] dis_rdata,

    output logic              ram_cs_n,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   starve_cnt;
    logic               rd_valid_q;
    owner_e             rd_owner_q;
    logic [N_REQ-1:0]   grant_oh;
    logic               arb_en;
    logic               dis_starved;

    // Arbitration only in IDLE; gating with reset_n keeps grants low while reset is held
    assign arb_en      = (state_q == ST_IDLE) && reset_n;
    assign dis_starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    ext_frame_ram_prio_sel u_prio_sel (
        .df_req      (df_req  && arb_en),
        .mc_req      (mc_req  && arb_en),
        .dis_req     (dis_req && arb_en),
        .dis_starved (dis_starved),
        .grant_c     (grant_oh)
    );

    assign df_gnt  = grant_oh[GNT_DF];
    assign mc_gnt  = grant_oh[GNT_MC];
    assign dis_gnt = grant_oh[GNT_DIS];

    // Burst sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and RAM-side outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        ram_cs_n  = 1'b1;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        df_wready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_oh[GNT_DF]) begin
                    owner_d = OWN_DF;
                    addr_d  = df_addr;
                    cnt_d   = df_len;
                end else if (grant_oh[GNT_MC]) begin
                    owner_d = OWN_MC;
                    addr_d  = mc_addr;
                    cnt_d   = mc_len;
                end else if (grant_oh[GNT_DIS]) begin
                    owner_d = OWN_DIS;
                    addr_d  = dis_addr;
                    cnt_d   = dis_len;
                end
                if (grant_oh != '0) begin
                    state_d = ST_BURST;
                end
            end

            ST_BURST: begin
                busy      = 1'b1;
                ram_cs_n  = 1'b0;
                ram_addr  = addr_q;
                ram_wr    = (owner_q == OWN_DF);
                df_wready = (owner_q == OWN_DF);
                if (owner_q == OWN_DF) begin
                    ram_wdata = df_wdata;
                end
                // Natural overflow gives the wrap from the top address to 0
                addr_d = addr_q + ADDR_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // DIS wait counter; saturates so the promotion holds until DIS is served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!dis_req || dis_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Owner tag follows each read access by one cycle to match RAM read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_valid_q <= (state_q == ST_BURST) && is_read_owner(owner_q);
            rd_owner_q <= owner_q;
        end
    end

    assign mc_rvalid  = rd_valid_q && (rd_owner_q == OWN_MC);
    assign dis_rvalid = rd_valid_q && (rd_owner_q == OWN_DIS);
    assign mc_rdata   = mc_rvalid  ? ram_rdata : '0;
    assign dis_rdata  = dis_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ext_frame_ram_arbiter.sv
// Directed bench for ext_frame_ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_ext_frame_ram_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;

    logic              clk;
    logic              reset_n;
    logic              df_req, mc_req, dis_req;
    logic [ADDR_W-1:0] df_addr, mc_addr, dis_addr;
    logic [LEN_W-1:0]  df_len, mc_len, dis_len;
    logic [DATA_W-1:0] df_wdata;
    logic              df_gnt, df_wready, mc_gnt, mc_rvalid, dis_gnt, dis_rvalid;
    logic [DATA_W-1:0] mc_rdata, dis_rdata;
    logic              ram_cs_n, ram_wr, busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    ext_frame_ram_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .df_req     (df_req),
        .df_addr    (df_addr),
        .df_len     (df_len),
        .df_wdata   (df_wdata),
        .df_gnt     (df_gnt),
        .df_wready  (df_wready),
        .mc_req     (mc_req),
        .mc_addr    (mc_addr),
        .mc_len     (mc_len),
        .mc_gnt     (mc_gnt),
        .mc_rvalid  (mc_rvalid),
        .mc_rdata   (mc_rdata),
        .dis_req    (dis_req),
        .dis_addr   (dis_addr),
        .dis_len    (dis_len),
        .dis_gnt    (dis_gnt),
        .dis_rvalid (dis_rvalid),
        .dis_rdata  (dis_rdata),
        .ram_cs_n   (ram_cs_n),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    // RAM model: read data appears one cycle after the access
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_wr) begin
            ram_rdata <= rd_model(ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [31:0] gnts();
        return {29'd0, df_gnt, mc_gnt, dis_gnt};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] exp_a [4];
        logic [2:0]        exp_g [5];
        int                found;
        int                df_count;
        int                cyc;

        reset_n  = 1'b0;
        df_req   = 1'b1;
        mc_req   = 1'b0;
        dis_req  = 1'b0;
        df_addr  = '0;
        mc_addr  = '0;
        dis_addr = '0;
        df_len   = '0;
        mc_len   = '0;
        dis_len  = '0;
        df_wdata = '0;
        ram_rdata = '0;

        // Reset state, with a request held to prove grants stay low
        repeat (2) settle();
        check1("rst_cs_n", ram_cs_n, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check ("rst_gnts", gnts(), 32'd0);
        check1("rst_wr", ram_wr, 1'b0);
        check ("rst_addr", 32'(ram_addr), 32'd0);
        check1("rst_rvalid", mc_rvalid | dis_rvalid | df_wready, 1'b0);
        df_req  = 1'b0;
        reset_n = 1'b1;

        // Single DF write burst
        tick();
        df_req  = 1'b1;
        df_addr = 14'h0100;
        df_len  = 4'd3;
        settle();
        check("df_gnt", gnts(), 32'h4);
        tick();
        df_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            df_wdata = 32'hA0 + 32'(i);
            settle();
            check1("df_cs_n", ram_cs_n, 1'b0);
            check1("df_wr", ram_wr, 1'b1);
            check1("df_wready", df_wready, 1'b1);
            check ("df_addr", 32'(ram_addr), 32'h0100 + 32'(i));
            check ("df_wdata", ram_wdata, 32'hA0 + 32'(i));
        end
        tick();
        settle();
        check1("df_gap_cs_n", ram_cs_n, 1'b1);
        check1("df_gap_busy", busy, 1'b0);
        check1("df_no_rvalid", mc_rvalid | dis_rvalid, 1'b0);

        // MC read with address wrap
        exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        tick();
        mc_req  = 1'b1;
        mc_addr = 14'h3FFE;
        mc_len  = 4'd3;
        settle();
        check("mc_gnt", gnts(), 32'h2);
        tick();
        mc_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            settle();
            if (i < 4) begin
                check1("mc_cs_n", ram_cs_n, 1'b0);
                check1("mc_wr", ram_wr, 1'b0);
                check ("mc_addr", 32'(ram_addr), 32'(exp_a[i]));
            end else begin
                check1("mc_end_cs_n", ram_cs_n, 1'b1);
            end
            if (i == 0) begin
                check1("mc_rvalid_early", mc_rvalid, 1'b0);
            end else begin
                check1("mc_rvalid", mc_rvalid, 1'b1);
                check ("mc_rdata", mc_rdata, rd_model(exp_a[i-1]));
                check1("mc_dis_quiet", dis_rvalid, 1'b0);
            end
        end

        // Simultaneous single-word requests
        exp_g = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
        tick();
        df_req = 1'b1; mc_req = 1'b1; dis_req = 1'b1;
        df_len = '0;   mc_len = '0;   dis_len = '0;
        df_addr = 14'h0010; mc_addr = 14'h0020; dis_addr = 14'h0030;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            if (k == 1) df_req = 1'b0;
            if (k == 3) mc_req = 1'b0;
            settle();
            check("sim_gnts", gnts(), {29'd0, exp_g[k]});
            if (k == 3) check("sim_mc_addr", 32'(ram_addr), 32'h0020);
        end
        tick();
        dis_req = 1'b0;
        settle();
        check("sim_dis_addr", 32'(ram_addr), 32'h0030);
        tick();
        settle();
        check1("sim_dis_rvalid", dis_rvalid, 1'b1);
        check ("sim_dis_rdata", dis_rdata, rd_model(14'h0030));
        check1("sim_mc_quiet", mc_rvalid, 1'b0);

        // Starvation: DF and MC hog the RAM with 16-word bursts
        tick();
        df_req = 1'b1; mc_req = 1'b1; dis_req = 1'b1;
        df_len = 4'd15; mc_len = 4'd15; dis_len = 4'd15;
        df_addr = 14'h1000; mc_addr = 14'h2000; dis_addr = 14'h0400;
        found = -1;
        df_count = 0;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) tick();
            settle();
            if (df_gnt) df_count++;
            if (dis_gnt) begin
                found = cyc;
                break;
            end
        end
        check("starve_dis_gnt_cycle", 32'(found), 32'd68);
        check("starve_df_grants", 32'(df_count), 32'd4);
        tick();
        df_req = 1'b0; mc_req = 1'b0; dis_req = 1'b0;
        settle();
        check("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
        check("starve_dis_addr", 32'(ram_addr), 32'h0400);
        for (cyc = 0; cyc < 40 && busy; cyc++) begin
            tick();
            settle();
        end
        check1("starve_burst_done", busy, 1'b0);

        // Reset during the third word of a 16-word MC read
        tick();
        mc_req  = 1'b1;
        mc_addr = 14'h0500;
        mc_len  = 4'd15;
        settle();
        check("rmb_mc_gnt", gnts(), 32'h2);
        tick();
        tick();
        tick();
        #1;
        check("rmb_word3_addr", 32'(ram_addr), 32'h0502);
        check1("rmb_word3_rvalid", mc_rvalid, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("rmb_cs_n", ram_cs_n, 1'b1);
        check1("rmb_busy", busy, 1'b0);
        check ("rmb_gnts", gnts(), 32'd0);
        check1("rmb_rvalid", mc_rvalid | dis_rvalid, 1'b0);
        mc_req = 1'b0;
        settle();
        reset_n = 1'b1;
        tick();
        dis_req  = 1'b1;
        dis_addr = 14'h0200;
        dis_len  = 4'd1;
        settle();
        check("post_dis_gnt", gnts(), 32'h1);
        tick();
        dis_req = 1'b0;
        settle();
        check1("post_cs_n", ram_cs_n, 1'b0);
        check ("post_addr0", 32'(ram_addr), 32'h0200);
        tick();
        settle();
        check ("post_addr1", 32'(ram_addr), 32'h0201);
        check1("post_rvalid0", dis_rvalid, 1'b1);
        check ("post_rdata0", dis_rdata, rd_model(14'h0200));
        tick();
        settle();
        check1("post_end_cs_n", ram_cs_n, 1'b1);
        check1("post_rvalid1", dis_rvalid, 1'b1);
        check ("post_rdata1", dis_rdata, rd_model(14'h0201));
        check1("post_mc_quiet", mc_rvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_frame_ram_arbiter.md
Name: ext_frame_ram_arbiter

Overview:
- Shares one external frame RAM port between three requesters: deblocking-filter writeback (DF), motion-compensation reference fetch (MC) and display readout (DIS).
- Performs fixed-priority arbitration with anti-starvation for DIS, then sequences burst accesses and routes read data back to the owner.
- One instance sits in front of each external frame RAM (RAM0, RAM1) inside nova.

Parameters:
ADDR_W, 14, RAM word address width
DATA_W, 32, RAM data width
LEN_W, 4, burst length field width; a burst is len+1 words (1..16)
STARVE_LIMIT, 64, cycles DIS may wait before it is promoted to top priority

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
df_req  in  1  DF write burst request, level; held until df_gnt
df_addr  in  ADDR_W  DF burst start address
df_len  in  LEN_W  DF burst length minus one
df_wdata  in  DATA_W  DF write word, sampled when df_wready=1
df_gnt  out  1  one-cycle grant pulse to DF
df_wready  out  1  current DF word written this cycle
mc_req  in  1  MC read burst request
mc_addr  in  ADDR_W  MC start address
mc_len  in  LEN_W  MC length minus one
mc_gnt  out  1  grant pulse to MC
mc_rvalid  out  1  mc_rdata valid
mc_rdata  out  DATA_W  MC read data
dis_req  in  1  DIS read burst request
dis_addr  in  ADDR_W  DIS start address
dis_len  in  LEN_W  DIS length minus one
dis_gnt  out  1  grant pulse to DIS
dis_rvalid  out  1  dis_rdata valid
dis_rdata  out  DATA_W  DIS read data
ram_cs_n  out  1  RAM chip select, active low
ram_wr  out  1  1=write, 0=read; meaningful only when ram_cs_n=0
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read access
busy  out  1  a burst is in progress

Behaviour:
- Interface decided: single clock clk; reset_n is asynchronous and active-low.
- Reset values: ram_cs_n=1; all other outputs 0; state IDLE; starvation counter 0. Assertion of reset mid-burst aborts the burst immediately; there is no resume.
- States:
  - IDLE: arbitrate among requests asserted this cycle. Priority is DF > MC > DIS, except DIS is first when starve_cnt >= STARVE_LIMIT. On a win: pulse the owner's gnt, latch its addr and len, record the owner, and go to BURST next cycle. No request: stay in IDLE.
  - BURST: ram_cs_n=0 every cycle, ram_addr = current address, ram_wr=1 for DF and 0 otherwise. Address increments by 1 per word and wraps from 2^ADDR_W-1 to 0. The word counter counts down from len; the state returns to IDLE after the word with count 0.
- Timing:
  - Grant to first access: 1 cycle.
  - A burst of N words occupies N consecutive cycles, followed by a mandatory IDLE arbitration cycle with ram_cs_n=1. This gap is the bus turnaround.
  - Back-to-back bursts therefore cost N+1 cycles each.
- DF writes: df_wready=1 in each DF BURST cycle; ram_wdata=df_wdata combinationally. DF must present the next word in the cycle after each wready.
- Reads: the owner's rvalid is asserted and rdata=ram_rdata exactly one cycle after each read access. The owner tag is delayed one cycle so the last word of a burst is returned correctly during the following IDLE or BURST cycle. The other requester's rvalid stays 0.
- starve_cnt:
  - Increments each cycle dis_req=1 && dis_gnt=0, saturating at STARVE_LIMIT.
  - Clears on dis_gnt or when dis_req=0.
- Simultaneous requests resolve in a single IDLE cycle. Non-winners keep req asserted and are considered at the next IDLE.
- Requests dropped mid-burst are ignored; the burst always completes its len+1 words.
- Requests arriving during BURST are not granted until the next IDLE.
- busy=1 in BURST.

Decomposition:
- Shared package nova_ram_arb_pkg holds:
  - owner enum {OWN_NONE, OWN_DF, OWN_MC, OWN_DIS};
  - state enum {ST_IDLE, ST_BURST};
  - default width constants ADDR_W, DATA_W, LEN_W.
- Sub-module ext_frame_ram_prio_sel: combinational 3-way priority select with starvation override, producing a one-hot grant.
- The sequencer, counters and read-return pipeline stay in the top.

Test Plan:
- Single DF write: addr=0x0100, len=3, wdata 0xA0..0xA3 → df_gnt at cycle t; writes to 0x0100..0x0103 at t+1..t+4 with ram_wr=1; ram_cs_n=1 at t+5.
- MC read: addr=0x3FFE, len=3 → ram_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; mc_rvalid high t+2..t+5 carrying the model data; dis_rvalid stays 0.
- Simultaneous requests: df, mc and dis all asserted in the same cycle, each len=0 → grant order DF, MC, DIS on cycles t, t+2, t+4.
- Starvation: dis_req held while DF and MC request continuously with len=15 → dis_gnt no later than the first IDLE after starve_cnt reaches 64; starve_cnt then clears.
- Reset mid-burst: assert reset_n=0 during the 3rd word of a 16-word MC read → ram_cs_n=1 and all gnt/rvalid outputs 0 asynchronously; after release, IDLE and a new DIS request is granted normally.
